// File: rtl/fsm_symbol_feeder.sv
// Symbol FIFO feeding a downstream 2-bit FSM input: each queued symbol is held
// on sym_out for max(hold_cycles,1) cycles, back-to-back while symbols remain.
module fsm_symbol_feeder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HOLD_W   = 4,
  parameter logic [1:0]  IDLE_SYM = 2'b00
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [1:0]                in_sym,
  output logic                      in_ready,
  input  logic [HOLD_W-1:0]         hold_cycles,
  input  logic                      flush,
  output logic [1:0]                sym_out,
  output logic                      sym_active,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;
  logic [HOLD_W-1:0]   hold_load;
  logic [1:0]          sym_next;
  logic                active_next;
  logic                push;
  logic                pop;

  assign in_ready  = (fifo_count < CW'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  // hold_cycles == 0 behaves as 1, so the reload value saturates at zero
  assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (fifo_count != '0) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sym_next    = sym_out;
    active_next = sym_active;
    hold_next   = hold_cnt;
    if (pop) begin
      sym_next    = mem[rd_ptr];
      active_next = 1'b1;
      hold_next   = hold_load;
    end else if (state == HOLD && hold_cnt != '0) begin
      hold_next = hold_cnt - HOLD_W'(1);
    end else if (state == HOLD) begin
      sym_next    = IDLE_SYM;
      active_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hold_cnt   <= '0;
      sym_out    <= IDLE_SYM;
      sym_active <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      hold_cnt   <= hold_next;
      sym_out    <= sym_next;
      sym_active <= active_next;
    end
  end

endmodule

// File: tb/tb_fsm_symbol_feeder.sv
// Scoreboard bench for fsm_symbol_feeder: accepted symbols queue up in a
// presentation-timeline model; a monitor compares every cycle's outputs.
module tb_fsm_symbol_feeder;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [1:0]        in_sym;
  logic              in_ready;
  logic [HOLD_W-1:0] hold_cycles;
  logic              flush;
  logic [1:0]        sym_out;
  logic              sym_active;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_symbol_feeder #(
    .DEPTH   (DEPTH),
    .HOLD_W  (HOLD_W),
    .IDLE_SYM(2'b00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sym     (in_sym),
    .in_ready   (in_ready),
    .hold_cycles(hold_cycles),
    .flush      (flush),
    .sym_out    (sym_out),
    .sym_active (sym_active),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: timeline model. A symbol accepted at edge a may start at edge
  // a+1 at the earliest, and never before the previous one has run its hold.
  initial begin
    int         cyc = 0;
    int         cur_end = 0;
    bit         cur_on = 1'b0;
    logic [1:0] cur_sym = 2'b00;
    logic [1:0] q[$];
    logic       c_rst, c_flush, c_valid, c_ready;
    logic [1:0] c_sym;
    logic [HOLD_W-1:0] c_hold;
    bit         exp_ready;
    int         h;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      c_rst   = reset_n;
      c_flush = flush;
      c_valid = in_valid;
      c_ready = in_ready;
      c_sym   = in_sym;
      c_hold  = hold_cycles;
      @(posedge clk);
      #1;
      cyc++;
      exp_ready = (q.size() < DEPTH) && !c_flush;
      chk("in_ready", c_ready, exp_ready);
      if (!c_rst || c_flush) begin
        q.delete();
        cur_on = 1'b0;
      end else begin
        if (!(cur_on && cyc < cur_end)) begin
          if (q.size() > 0) begin
            cur_sym = q.pop_front();
            cur_on  = 1'b1;
            h       = (c_hold == 0) ? 1 : int'(c_hold);
            cur_end = cyc + h;
          end else begin
            cur_on = 1'b0;
          end
        end
        if (c_valid && exp_ready) q.push_back(c_sym);
      end
      chk("sym_active", sym_active, cur_on);
      chk("sym_out", sym_out, cur_on ? cur_sym : 2'b00);
      chk("fifo_count", fifo_count, q.size());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one symbol and keep it offered until accepted; starts and ends at a negedge.
  task automatic send(input logic [1:0] s);
    bit rdy = 1'b0;
    in_valid = 1'b1;
    in_sym   = s;
    for (int t = 0; t < 500; t++) begin
      #1;
      rdy = in_ready;
      @(negedge clk);
      if (rdy) break;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted sym %0d", s);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (fifo_count == 0 && !sym_active) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  initial begin
    int exp_s[5] = '{1, 1, 2, 2, 0};
    int exp_a[5] = '{1, 1, 1, 1, 0};
    int acc;
    int guard;

    reset_n = 1'b0; in_valid = 1'b0; in_sym = 2'b00; hold_cycles = 4'd1; flush = 1'b0;
    tick(3);
    reset_n = 1'b1;
    #1 chk("ready_after_reset", in_ready, 1);
    tick(2);

    // Latency and hold: 01 then 10 with hold 2
    hold_cycles = 4'd2;
    tick(1);
    in_valid = 1'b1; in_sym = 2'b01;
    @(posedge clk); #1;
    chk("latency_k", sym_active, 0);
    @(negedge clk);
    in_sym = 2'b10;
    @(posedge clk); #1;
    chk("seq_sym0", sym_out, exp_s[0]);
    chk("seq_act0", sym_active, exp_a[0]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("seq_sym%0d", i), sym_out, exp_s[i]);
      chk($sformatf("seq_act%0d", i), sym_active, exp_a[i]);
    end
    @(negedge clk);
    wait_drain();

    // Full FIFO with long hold
    hold_cycles = 4'd15;
    send(2'd0); send(2'd1); send(2'd2); send(2'd3); send(2'd1);
    chk("full_count", fifo_count, 4);
    chk("full_ready", in_ready, 0);
    send(2'd2);
    wait_drain();

    // Zero hold: one cycle each, no gaps
    hold_cycles = 4'd0;
    send(2'd3); send(2'd0); send(2'd2);
    wait_drain();

    // Flush mid-hold with a push in the same cycle
    hold_cycles = 4'd8;
    send(2'd1); send(2'd2); send(2'd3); send(2'd1);
    tick(2);
    chk("pre_flush_count", fifo_count, 3);
    flush = 1'b1; in_valid = 1'b1; in_sym = 2'd3;
    @(posedge clk); #1;
    chk("flush_count", fifo_count, 0);
    chk("flush_active", sym_active, 0);
    chk("flush_sym", sym_out, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tick(20);

    // Reset mid-hold overriding flush and in_valid
    send(2'd2); send(2'd3); send(2'd1);
    tick(2);
    reset_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_sym = 2'd2;
    @(posedge clk); #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_active", sym_active, 0);
    chk("rst_sym", sym_out, 0);
    @(negedge clk);
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1 chk("rst_release_ready", in_ready, 1);
    tick(30);

    // Pointer wrap: 3*DEPTH symbols with hold 1 and random in_valid
    hold_cycles = 4'd1;
    acc = 0;
    guard = 0;
    while (acc < 3 * DEPTH && guard < 2000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sym   = 2'($urandom_range(0, 3));
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    wait_drain();

    // Random hold changes mid-hold and occasional flush
    for (int i = 0; i < 200; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_sym      = 2'($urandom_range(0, 3));
      hold_cycles = HOLD_W'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
    wait_drain();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
